// File: rtl/mul_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one radix-2 step per cycle.
// Latency: start in cycle 0 -> done in cycle WIDTH+2 (divide-by-zero: cycle 1).
// Backpressure: asserts freeze to hold IF/ID/EXE while in flight; start ignored while busy.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             freeze,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic               dbz_r;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Operand conditioning: op[0] == 0 selects the signed variants.
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_signed = ~op[0];
    assign a_neg     = op_signed & src_a[WIDTH-1];
    assign b_neg     = op_signed & src_b[WIDTH-1];
    assign abs_a     = a_neg ? -src_a : src_a;
    assign abs_b     = b_neg ? -src_b : src_b;

    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    assign rem_sh   = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, mcand};
    assign trial_ok = ~trial[WIDTH+1];
    assign rem_next = trial_ok ? trial[WIDTH:0] : rem_sh;
    assign quo_next = {acc[WIDTH-2:0], trial_ok};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz_r  <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            rem    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        is_div <= op[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        cnt    <= '0;
                        rem    <= '0;
                        if (op[1] && (src_b == '0)) begin
                            hi_r  <= src_a;
                            lo_r  <= '1;
                            dbz_r <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mcand <= op[1] ? abs_b : abs_a;
                            acc   <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            rem <= rem_next;
                            acc <= {{WIDTH{1'b0}}, quo_next};
                        end else begin
                            acc <= mul_next;
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_STEP) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end else begin
                            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix[WIDTH-1:0];
                        end
                        state <= S_DONE;
                    end
                end
                default: begin
                    // Result is already committed, so flush has nothing to undo here.
                    dbz_r <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign freeze      = ((state == S_IDLE) & start & ~flush) | (state == S_CALC) | (state == S_FIX);
    assign done        = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) & dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer: directed vectors, monitor pops on each done pulse.
module tb_mul_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        freeze;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_div_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .freeze      (freeze),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input logic d);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.dbz = d;
        sb.push_back(e);
    endtask

    // Drives start for exactly one cycle (cycle 0); returns just after the edge opening cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of negedges observed until done (first one is cycle 1), -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic d, input int exp_cyc);
        int cyc;
        push(h, l, d);
        issue(o, a, b);
        wait_done(cyc);
        check({nm, "_latency"}, cyc, exp_cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: hi=%h lo=%h with no result outstanding", hi, lo);
                end else begin
                    e = sb.pop_front();
                    check("result_hi", hi, e.hi);
                    check("result_lo", lo, e.lo);
                    check("result_dbz", div_by_zero, e.dbz);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcyc;
        int frz_bad;
        int nd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {busy, freeze, done, div_by_zero}, 4'b0000);
        check("reset_hilo", {hi, lo}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // MULT 7 x -3 with cycle-accurate freeze/done tracking.
        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd7;
        src_b = 32'hFFFF_FFFD;
        @(negedge clk);
        frz_bad = (freeze !== 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcyc  = -1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (freeze !== (c < 34)) frz_bad++;
            if (done && dcyc < 0) dcyc = c;
        end
        check("mult_done_cycle", dcyc, 34);
        check("mult_freeze", frz_bad, 0);

        run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        run("mult_negneg", 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'd20, 1'b0, 34);
        run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run("div_negdivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
        run("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
        run("divu_by_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
        run("div_by_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1);
        run("divu_basic", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

        // Flush in cycle 10 of a MULT: no done, HI/LO keep the DIVU result.
        issue(2'b00, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 1'b0);
        check("flush_hilo", {hi, lo}, {32'd2, 32'd14});
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush_no_done", nd, 0);

        // Second start in cycle 5 of a DIV is ignored.
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'hFFFF_FFFF;
        src_b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dcyc);
        check("busy_start_latency", (dcyc < 0) ? -1 : dcyc + 5, 34);

        // Flush coinciding with start: the start is dropped.
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        src_a = 32'd2;
        src_b = 32'd3;
        @(negedge clk);
        check("start_flush_freeze", freeze, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("start_flush_busy", busy, 1'b0);

        // Reset in cycle 20 of a DIVU clears everything; a fresh op then completes.
        issue(2'b11, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_ctrl", {busy, freeze, done}, 3'b000);
        check("midreset_hilo", {hi, lo}, 64'h0);
        run("post_reset_multu", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 34);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
